// File: rtl/sap_cpu_param.sv
// ---------------------------------------------------------------------------
// sap_cpu_param
//
// Parametrised micro-sequenced accumulator CPU. The datapath has PC, MAR,
// RAM, IR, A, B, an ALU, Z/C flags and an output register. Instructions are
// variable length: each opcode returns to FETCH after its last execute
// step, so there is no fixed step frame.
//
// Instruction word: opcode = ir[DATA_W-1 -: 4], operand = ir[ADDR_W-1:0].
// Immediates are the zero-extended operand. DATA_W must be >= ADDR_W + 4 so
// that the opcode and operand fields do not overlap.
//
// Ports:
//   clk             system clock, rising-edge active
//   reset           asynchronous active-high reset; RAM is not cleared
//   prog            1 = programming mode: write RAM every cycle, hold core
//   addr            RAM write address while prog=1
//   programm_input  RAM write data while prog=1
//   output_register value latched by OUT
//   out_valid       one-cycle pulse in the cycle after an OUT executes
//   halted          high while the core sits in HALT
//   pc_dbg          current program counter
// ---------------------------------------------------------------------------
module sap_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] programm_input,
    output logic [DATA_W-1:0] output_register,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_STA = 4'b0101;
    localparam logic [3:0] OP_LDI = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_JMZ = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1001;
    localparam logic [3:0] OP_JMC = 4'b1010;
    localparam logic [3:0] OP_JNZ = 4'b1011;
    localparam logic [3:0] OP_ADI = 4'b1100;
    localparam logic [3:0] OP_SBI = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EX1    = 3'd2,
        EX2    = 3'd3,
        EX3    = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Program/data memory. Not reset so it maps onto block RAM; the read
    // address is the registered MAR.
    logic [DATA_W-1:0] ram [DEPTH];

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              z_reg;
    logic              c_reg;
    logic [DATA_W-1:0] out_reg;
    logic              out_valid_reg;
    logic              halted_reg;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] ram_rd;

    logic              alu_sub;
    logic [DATA_W-1:0] alu_rhs;
    logic [DATA_W:0]   alu_res;
    logic              alu_z;
    logic              alu_c;
    logic              sta_we;

    // Middle IR bits between opcode and operand carry no meaning.
    logic              unused_ir;

    assign opcode    = ir_reg[DATA_W-1 -: 4];
    assign operand   = ir_reg[ADDR_W-1:0];
    assign imm       = {{(DATA_W-ADDR_W){1'b0}}, operand};
    assign ram_rd    = ram[mar_reg];
    assign unused_ir = ^ir_reg;

    // ALU: one (DATA_W+1)-bit adder/subtractor. In EX3 the right operand is
    // B (ADD/SUB/CMP); in EX1 it is the immediate (ADI/SBI). Bit DATA_W is
    // carry on add and borrow on subtract.
    always_comb begin
        alu_sub = (opcode == OP_SUB) || (opcode == OP_CMP) || (opcode == OP_SBI);
        alu_rhs = (state_reg == EX3) ? b_reg : imm;
        if (alu_sub) begin
            alu_res = {1'b0, a_reg} - {1'b0, alu_rhs};
        end else begin
            alu_res = {1'b0, a_reg} + {1'b0, alu_rhs};
        end
        alu_z = (alu_res[DATA_W-1:0] == '0);
        alu_c = alu_res[DATA_W];
    end

    assign sta_we = (state_reg == EX2) && (opcode == OP_STA);

    // RAM write port. Programming has priority and abandons any STA in
    // flight; an STA write is also suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (prog) begin
            ram[addr] <= programm_input;
        end else if (!reset && sta_we) begin
            ram[mar_reg] <= a_reg;
        end
    end

    // Control sequencer and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= FETCH;
            pc_reg        <= '0;
            mar_reg       <= '0;
            ir_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
        end else if (prog) begin
            // Hold the core at the start of the program; data registers
            // keep their values across programming.
            state_reg     <= FETCH;
            pc_reg        <= '0;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                FETCH: begin
                    mar_reg   <= pc_reg;
                    state_reg <= DECODE;
                end
                DECODE: begin
                    ir_reg    <= ram_rd;
                    pc_reg    <= pc_reg + ADDR_W'(1);
                    state_reg <= EX1;
                end
                EX1: begin
                    state_reg <= FETCH;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_CMP, OP_STA: begin
                            mar_reg   <= operand;
                            state_reg <= EX2;
                        end
                        OP_OUT: begin
                            out_reg       <= a_reg;
                            out_valid_reg <= 1'b1;
                        end
                        OP_JMP: pc_reg <= operand;
                        OP_LDI: a_reg  <= imm;
                        OP_JMZ: if (z_reg)  pc_reg <= operand;
                        OP_JMC: if (c_reg)  pc_reg <= operand;
                        OP_JNZ: if (!z_reg) pc_reg <= operand;
                        OP_ADI, OP_SBI: begin
                            a_reg <= alu_res[DATA_W-1:0];
                            z_reg <= alu_z;
                            c_reg <= alu_c;
                        end
                        OP_HLT: begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
                        end
                        default: ; // NOP and the reserved opcode
                    endcase
                end
                EX2: begin
                    state_reg <= FETCH;
                    case (opcode)
                        OP_LDA: a_reg <= ram_rd;
                        OP_ADD, OP_SUB, OP_CMP: begin
                            b_reg     <= ram_rd;
                            state_reg <= EX3;
                        end
                        default: ; // STA writes through the RAM port
                    endcase
                end
                EX3: begin
                    // CMP shares the subtract path but only updates flags.
                    if (opcode != OP_CMP) begin
                        a_reg <= alu_res[DATA_W-1:0];
                    end
                    z_reg     <= alu_z;
                    c_reg     <= alu_c;
                    state_reg <= FETCH;
                end
                HALT: state_reg <= HALT;
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign output_register = out_reg;
    assign out_valid       = out_valid_reg;
    assign halted          = halted_reg;
    assign pc_dbg          = pc_reg;

endmodule

// File: tb/tb_sap_cpu_param.sv
module tb_sap_cpu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        prog8, prog12;
    logic [3:0]  addr8;
    logic [7:0]  pin8;
    logic [7:0]  out8;
    logic        ov8, h8;
    logic [3:0]  pc8;
    logic [5:0]  addr12;
    logic [11:0] pin12;
    logic [11:0] out12;
    logic        ov12, h12;
    logic [5:0]  pc12;

    sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut8 (
        .clk(clk), .reset(reset), .prog(prog8), .addr(addr8),
        .programm_input(pin8), .output_register(out8), .out_valid(ov8),
        .halted(h8), .pc_dbg(pc8)
    );

    sap_cpu_param #(.DATA_W(12), .ADDR_W(6)) dut12 (
        .clk(clk), .reset(reset), .prog(prog12), .addr(addr12),
        .programm_input(pin12), .output_register(out12), .out_valid(ov12),
        .halted(h12), .pc_dbg(pc12)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] cap_q[$];
    int          cap_cyc_q[$];

    function automatic logic [7:0] enc8(input logic [3:0] op, input logic [3:0] opd);
        return {op, opd};
    endfunction

    function automatic logic [11:0] enc12(input logic [3:0] op, input logic [5:0] opd);
        return {op, 2'b00, opd};
    endfunction

    task automatic prog_word(input int sel, input int a, input logic [15:0] d);
        @(negedge clk);
        if (sel == 0) begin
            prog8 = 1'b1; addr8 = a[3:0]; pin8 = d[7:0];
        end else begin
            prog12 = 1'b1; addr12 = a[5:0]; pin12 = d[11:0];
        end
        @(posedge clk);
    endtask

    task automatic prog_end();
        @(negedge clk);
        prog8 = 1'b0;
        prog12 = 1'b0;
    endtask

    // Runs the selected core until it halts or the cycle budget expires,
    // capturing every out_valid pulse and the edge index it followed.
    task automatic run_core(input int sel, input int max_cycles, output int used);
        bit done;
        done = 1'b0;
        used = 0;
        cap_q.delete();
        cap_cyc_q.delete();
        for (int i = 1; i <= max_cycles && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            used = i;
            if (sel == 0) begin
                if (ov8) begin cap_q.push_back(16'(out8)); cap_cyc_q.push_back(i); end
                if (h8) done = 1'b1;
            end else begin
                if (ov12) begin cap_q.push_back(16'(out12)); cap_cyc_q.push_back(i); end
                if (h12) done = 1'b1;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out8 !== 8'h00) begin failures++; $display("FAIL reset_out8 got=%h exp=00", out8); end
        checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL reset_ov8 got=%b exp=0", ov8); end
        checks++; if (h8 !== 1'b0) begin failures++; $display("FAIL reset_halted8 got=%b exp=0", h8); end
        checks++; if (pc8 !== 4'h0) begin failures++; $display("FAIL reset_pc8 got=%h exp=0", pc8); end
        checks++; if (pc12 !== 6'h0 || out12 !== 12'h0) begin failures++; $display("FAIL reset_12 got pc=%h out=%h exp 0 0", pc12, out12); end
        reset = 1'b0;
    endtask

    task automatic test_ldi_adi();
        int used;
        logic [15:0] e, g;
        prog_word(0, 0, 16'(enc8(4'h6, 4'd5)));
        prog_word(0, 1, 16'(enc8(4'hC, 4'd3)));
        prog_word(0, 2, 16'(enc8(4'h3, 4'd0)));
        prog_word(0, 3, 16'(enc8(4'hF, 4'd0)));
        prog_end();
        exp_q.push_back(16'd8);
        run_core(0, 100, used);
        checks++; if (cap_cyc_q.size() == 0 || cap_cyc_q[0] != 9) begin failures++; $display("FAIL ldi_adi_outcycle got=%0d exp=9", (cap_cyc_q.size() == 0) ? -1 : cap_cyc_q[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL ldi_adi_out got=%h exp=%h", g, e); end
        end
        checks++; if (cap_q.size() != 0) begin failures++; $display("FAIL ldi_adi_extra got=%0d extra outputs exp=0", cap_q.size()); end
        checks++; if (h8 !== 1'b1) begin failures++; $display("FAIL ldi_adi_halted got=%b exp=1", h8); end
        checks++; if (pc8 !== 4'd4) begin failures++; $display("FAIL ldi_adi_pc got=%0d exp=4", pc8); end
    endtask

    task automatic test_sub_borrow();
        int used;
        logic [15:0] e, g;
        prog_word(0, 0, 16'(enc8(4'h1, 4'd14)));
        prog_word(0, 1, 16'(enc8(4'h7, 4'd15)));
        prog_word(0, 2, 16'(enc8(4'h3, 4'd0)));
        prog_word(0, 3, 16'(enc8(4'hF, 4'd0)));
        prog_word(0, 14, 16'd3);
        prog_word(0, 15, 16'd5);
        prog_end();
        exp_q.push_back(16'h00FE);
        run_core(0, 100, used);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL sub_out got=%h exp=%h", g, e); end
        end
        checks++; if (dut8.c_reg !== 1'b1) begin failures++; $display("FAIL sub_carry got=%b exp=1", dut8.c_reg); end
        checks++; if (dut8.z_reg !== 1'b0) begin failures++; $display("FAIL sub_zero got=%b exp=0", dut8.z_reg); end
    endtask

    task automatic test_countdown();
        int used;
        logic [15:0] e, g;
        prog_word(0, 0, 16'(enc8(4'h6, 4'd3)));
        prog_word(0, 1, 16'(enc8(4'hD, 4'd1)));
        prog_word(0, 2, 16'(enc8(4'h3, 4'd0)));
        prog_word(0, 3, 16'(enc8(4'hB, 4'd1)));
        prog_word(0, 4, 16'(enc8(4'hF, 4'd0)));
        prog_end();
        exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
        run_core(0, 200, used);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL countdown_out got=%h exp=%h", g, e); end
        end
        checks++; if (cap_q.size() != 0) begin failures++; $display("FAIL countdown_extra got=%0d extra outputs exp=0", cap_q.size()); end
        checks++; if (h8 !== 1'b1 || dut8.z_reg !== 1'b1) begin failures++; $display("FAIL countdown_end got halted=%b z=%b exp 1 1", h8, dut8.z_reg); end
    endtask

    task automatic test_store_reload();
        int used;
        logic [15:0] e, g;
        prog_word(0, 12, 16'd0);
        prog_word(0, 0, 16'(enc8(4'h6, 4'd9)));
        prog_word(0, 1, 16'(enc8(4'h5, 4'd12)));
        prog_word(0, 2, 16'(enc8(4'h6, 4'd0)));
        prog_word(0, 3, 16'(enc8(4'h1, 4'd12)));
        prog_word(0, 4, 16'(enc8(4'h3, 4'd0)));
        prog_word(0, 5, 16'(enc8(4'hF, 4'd0)));
        prog_end();
        exp_q.push_back(16'd9);
        run_core(0, 100, used);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL store_out got=%h exp=%h", g, e); end
        end
        checks++; if (dut8.ram[12] !== 8'd9) begin failures++; $display("FAIL store_ram got=%h exp=09", dut8.ram[12]); end
    endtask

    task automatic test_wrap();
        int used;
        logic [15:0] e, g;
        pulse_reset();
        prog_word(0, 0, 16'(enc8(4'h8, 4'd5)));
        prog_word(0, 1, 16'(enc8(4'h6, 4'd1)));
        prog_word(0, 2, 16'(enc8(4'h4, 4'd15)));
        prog_word(0, 15, 16'(enc8(4'hD, 4'd1)));
        prog_word(0, 5, 16'(enc8(4'h3, 4'd0)));
        prog_word(0, 6, 16'(enc8(4'hF, 4'd0)));
        prog_end();
        exp_q.push_back(16'd0);
        run_core(0, 100, used);
        // JMZ, LDI, JMP, SBI (at 15), wrap to JMZ taken, then OUT: 6 x 3 edges.
        checks++; if (cap_cyc_q.size() == 0 || cap_cyc_q[0] != 18) begin failures++; $display("FAIL wrap_outcycle got=%0d exp=18", (cap_cyc_q.size() == 0) ? -1 : cap_cyc_q[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL wrap_out got=%h exp=%h", g, e); end
        end
        checks++; if (pc8 !== 4'd7 || h8 !== 1'b1) begin failures++; $display("FAIL wrap_end got pc=%0d halted=%b exp 7 1", pc8, h8); end
    endtask

    task automatic test_wide12();
        int used;
        logic [15:0] e, g;
        prog_word(1, 0, 16'(enc12(4'h1, 6'd40)));
        prog_word(1, 1, 16'(enc12(4'h2, 6'd41)));
        prog_word(1, 2, 16'(enc12(4'h3, 6'd0)));
        prog_word(1, 3, 16'(enc12(4'hF, 6'd0)));
        prog_word(1, 40, 16'h0FFF);
        prog_word(1, 41, 16'h0001);
        prog_end();
        exp_q.push_back(16'h0000);
        run_core(1, 100, used);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL wide_out got=%h exp=%h", g, e); end
        end
        checks++; if (dut12.z_reg !== 1'b1 || dut12.c_reg !== 1'b1) begin failures++; $display("FAIL wide_flags got z=%b c=%b exp 1 1", dut12.z_reg, dut12.c_reg); end
        checks++; if (h12 !== 1'b1 || pc12 !== 6'd4) begin failures++; $display("FAIL wide_end got halted=%b pc=%0d exp 1 4", h12, pc12); end
    endtask

    task automatic test_reset_mid_sta();
        int used;
        prog_word(0, 12, 16'h0055);
        prog_word(0, 0, 16'(enc8(4'h6, 4'd9)));
        prog_word(0, 1, 16'(enc8(4'h5, 4'd12)));
        prog_word(0, 2, 16'(enc8(4'hF, 4'd0)));
        prog_end();
        // LDI takes edges 1-3, STA edges 4-7; the next edge is STA's EX2.
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (dut8.a_reg !== 8'h00 || dut8.mar_reg !== 4'h0 || pc8 !== 4'h0) begin failures++; $display("FAIL midreset_regs got a=%h mar=%h pc=%h exp 00 0 0", dut8.a_reg, dut8.mar_reg, pc8); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (dut8.ram[12] !== 8'h55) begin failures++; $display("FAIL midreset_ram got=%h exp=55", dut8.ram[12]); end
        run_core(0, 100, used);
        checks++; if (used != 10 || h8 !== 1'b1) begin failures++; $display("FAIL midreset_rerun got cycles=%0d halted=%b exp 10 1", used, h8); end
        checks++; if (dut8.ram[12] !== 8'h09) begin failures++; $display("FAIL midreset_store got=%h exp=09", dut8.ram[12]); end
    endtask

    task automatic test_prog_mid();
        int used;
        logic [15:0] e, g;
        prog_word(0, 0, 16'(enc8(4'h6, 4'd3)));
        prog_word(0, 1, 16'(enc8(4'hD, 4'd1)));
        prog_word(0, 2, 16'(enc8(4'h3, 4'd0)));
        prog_word(0, 3, 16'(enc8(4'hB, 4'd1)));
        prog_word(0, 4, 16'(enc8(4'hF, 4'd0)));
        prog_end();
        repeat (8) @(posedge clk);
        prog_word(0, 0, 16'(enc8(4'h6, 4'd3)));
        #1;
        checks++; if (pc8 !== 4'h0 || h8 !== 1'b0) begin failures++; $display("FAIL progmid_pc got pc=%h halted=%b exp 0 0", pc8, h8); end
        checks++; if (dut8.a_reg !== 8'd2) begin failures++; $display("FAIL progmid_hold_a got=%h exp=02", dut8.a_reg); end
        prog_end();
        exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
        run_core(0, 200, used);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hDEAD;
            checks++; if (g !== e) begin failures++; $display("FAIL progmid_out got=%h exp=%h", g, e); end
        end
        checks++; if (h8 !== 1'b1) begin failures++; $display("FAIL progmid_halted got=%b exp=1", h8); end
    endtask

    initial begin
        prog8 = 1'b0; prog12 = 1'b0;
        addr8 = '0; pin8 = '0; addr12 = '0; pin12 = '0;
        test_reset();
        test_ldi_adi();
        test_sub_borrow();
        test_countdown();
        test_store_reload();
        test_wrap();
        test_wide12();
        test_reset_mid_sta();
        test_prog_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sap_cpu_param.md
Name: sap_cpu_param

Overview:
Parametrised successor to the team's 8-bit accumulator CPU. It keeps the same bus-less micro-sequenced datapath (PC, MAR, RAM, IR, A, B, ALU, Z/C flags, output register) and the same external RAM programming port. New over the previous generation: configurable data and address widths, variable-length instructions (no fixed 7-step frame), immediate ALU ops, inverse conditional jumps, HALT, and an output-strobe.

Parameters:
DATA_W, 8, accumulator/RAM word width; must satisfy DATA_W >= ADDR_W + 4
ADDR_W, 4, address width; RAM depth = 2**ADDR_W words

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all registers except RAM
prog  in  1  1 = programming mode: write RAM, hold core
addr  in  ADDR_W  RAM write address in programming mode
programm_input  in  DATA_W  RAM write data in programming mode
output_register  out  DATA_W  value latched by OUT
out_valid  out  1  one-cycle pulse, high in the cycle after output_register updates
halted  out  1  high while core is in HALT state
pc_dbg  out  ADDR_W  current PC, for bench observation

Behaviour:
- Single clock; reset is asynchronous and active-high, named clk/reset as in the existing CPU.
- Reset values: pc=0, mar=0, ir=0, A=0, B=0, Z=0, C=0, output_register=0, out_valid=0, halted=0, state=FETCH. RAM contents are not cleared.
- Instruction word: opcode = ir[DATA_W-1:DATA_W-4]; operand = ir[ADDR_W-1:0]. Immediates are the zero-extended operand.
- State machine: FETCH (mar<=pc) -> DECODE (ir<=ram[mar]; pc<=pc+1, wrapping mod 2**ADDR_W) -> EX1 -> EX2 -> EX3 -> FETCH. Each opcode returns to FETCH after its last listed step. HALT is an absorbing state.
- Opcodes and execute steps:
  - 0000 NOP: EX1 no-op.
  - 0001 LDA: EX1 mar<=op; EX2 A<=ram.
  - 0010 ADD: EX1 mar<=op; EX2 B<=ram; EX3 A<=A+B, flags.
  - 0011 OUT: EX1 output_register<=A.
  - 0100 JMP: EX1 pc<=op.
  - 0101 STA: EX1 mar<=op; EX2 ram[mar]<=A.
  - 0110 LDI: EX1 A<=imm.
  - 0111 SUB: as ADD with A-B.
  - 1000 JMZ: EX1 pc<=op if Z.
  - 1001 CMP: as SUB, flags only, A unchanged.
  - 1010 JMC: EX1 pc<=op if C.
  - 1011 JNZ: EX1 pc<=op if !Z.
  - 1100 ADI: EX1 A<=A+imm, flags.
  - 1101 SBI: EX1 A<=A-imm, flags.
  - 1110 reserved: executes as NOP.
  - 1111 HLT: EX1 -> HALT.
- Instruction latency in cycles: NOP/OUT/JMP/Jcc/LDI/ADI/SBI/HLT = 3; LDA/STA = 4; ADD/SUB/CMP = 5.
- ALU arithmetic is (DATA_W+1)-bit. C = result bit DATA_W: carry on add, borrow on subtract (A<B). Z = (result[DATA_W-1:0]==0). Flags update only on ADD/SUB/CMP/ADI/SBI, in the same edge as the A write.
- Conditional jumps sample the flags as they are at EX1. A flag written by the immediately preceding instruction is visible.
- out_valid is high for exactly one cycle, in the cycle following the OUT EX1 edge.
- HALT: no register changes; halted=1. Exit only via reset or prog.
- prog=1: ram[addr]<=programm_input every cycle. Core is forced synchronously to FETCH with pc=0, halted=0, out_valid=0. A, B, flags and output_register are held. Execution starts at pc=0 on the first cycle after prog falls.
- Simultaneous prog=1 with a pending STA: the prog write wins and the STA is abandoned.
- reset asserted mid-instruction: immediate abort to the reset values; the RAM write of an in-flight STA is suppressed while reset is high.

Test Plan:
- Load {LDI 5; ADI 3; OUT; HLT} -> output_register=8, out_valid pulses once at cycle 9 after prog falls, halted=1, pc_dbg=4.
- Load {LDA 14; SUB 15; OUT; HLT} with ram[14]=3, ram[15]=5 (DATA_W=8) -> output_register=0xFE, C=1, Z=0.
- Countdown loop {LDI 3; SBI 1; OUT; JNZ 1; HLT} -> outputs 2,1,0 in order; halts with Z=1.
- Store/reload {LDI 9; STA 12; LDI 0; LDA 12; OUT; HLT} -> output_register=9, ram[12]=9.
- JMP 15 at the last address with ADDR_W=4 -> after the jump, sequential PC wraps 15->0. Repeat with DATA_W=12, ADDR_W=6: ADD of 0xFFF+1 gives A=0, Z=1, C=1.
- Assert reset during EX2 of STA -> ram unchanged, all registers 0, next fetch from 0. Assert prog mid-program -> core restarts at pc=0 after prog falls.
